// File: rtl/hi_simulate_param.sv
`timescale 1ns/1ps
// hi_simulate_param: HF tag-emulator front end (hysteresis comparator, SSP return path, load modulation).
// Optional hysteresis timeout is enabled by defining HI_SIM_HYST_TIMEOUT_EN.
module hi_simulate_param #(
  parameter int ADC_W         = 8,
  parameter int HYST_HI       = 224,
  parameter int HYST_LO       = 31,
  parameter int TIMEOUT_W     = 12,
  parameter int DIV_W         = 9,
  parameter int FIELD_ON_CNT  = 64,
  parameter int FIELD_OFF_CNT = 256
) (
  input  logic             ck_1356meg,
  input  logic             rst_n,
  input  logic [ADC_W-1:0] adc_d,
  input  logic [3:0]       mod_type,
  input  logic             ssp_dout,
  output logic             adc_clk,
  output logic             ssp_clk,
  output logic             ssp_frame,
  output logic             ssp_din,
  output logic             pwr_oe4,
  output logic             pwr_lo,
  output logic             pwr_hi,
  output logic             pwr_oe1,
  output logic             pwr_oe2,
  output logic             pwr_oe3,
  output logic             field_on,
  output logic             dbg
);

  localparam logic [3:0] MOD_BPSK   = 4'd1;
  localparam logic [3:0] MOD_OOK212 = 4'd2;
  localparam logic [3:0] MOD_OOK424 = 4'd3;
  localparam logic [3:0] MOD_SSP8   = 4'd4;
  localparam logic [3:0] MOD_OOK848 = 4'd5;

  localparam logic [0:0] NO_FIELD = 1'b0;
  localparam logic [0:0] FIELD_ON = 1'b1;

  localparam int FMAX   = (FIELD_ON_CNT > FIELD_OFF_CNT) ? FIELD_ON_CNT : FIELD_OFF_CNT;
  localparam int FCNT_W = (FMAX > 2) ? $clog2(FMAX) : 1;

  localparam logic [ADC_W-1:0]  HI_V   = ADC_W'(HYST_HI);
  localparam logic [ADC_W-1:0]  LO_V   = ADC_W'(HYST_LO);
  localparam logic [FCNT_W-1:0] ON_TC  = FCNT_W'(FIELD_ON_CNT - 1);
  localparam logic [FCNT_W-1:0] OFF_TC = FCNT_W'(FIELD_OFF_CNT - 1);

  logic [DIV_W-1:0]  div;
  logic [FCNT_W-1:0] fcnt;
  logic [0:0]        state;
  logic [3:0]        frame_nib;
  logic              hyst;
  logic              dout_q;
  logic              ssp_clk_q;
  logic              ssp_clk_nxt;
  logic              sc;
  logic              adc_high;
  logic              adc_low;

  assign adc_clk  = ck_1356meg;
  assign pwr_lo   = 1'b0;
  assign pwr_hi   = 1'b0;
  assign pwr_oe1  = 1'b0;
  assign pwr_oe2  = 1'b0;
  assign pwr_oe3  = 1'b0;
  assign field_on = (state == FIELD_ON);
  assign dbg      = ssp_frame;

  assign adc_high = (adc_d >= HI_V);
  assign adc_low  = (adc_d <= LO_V);

  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

`ifdef HI_SIM_HYST_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tcnt;

  // A long run without a high sample forces hyst high so ssp_din cannot stick low.
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      hyst <= 1'b0;
      tcnt <= '0;
    end else if (adc_high) begin
      hyst <= 1'b1;
      tcnt <= '0;
    end else if (tcnt == {TIMEOUT_W{1'b1}}) begin
      hyst <= 1'b1;
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TIMEOUT_W'(1);
      if (adc_low) hyst <= 1'b0;
    end
  end
`else
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      hyst <= 1'b0;
    end else if (adc_high) begin
      hyst <= 1'b1;
    end else if (adc_low) begin
      hyst <= 1'b0;
    end
  end
`endif

  // Mode-dependent SSP timing and subcarrier selection, all taken from the free-running divider.
  always_comb begin
    ssp_clk_nxt = ~div[4];
    frame_nib   = div[7:4];
    sc          = 1'b0;
    case (mod_type)
      MOD_BPSK:   sc = dout_q ^ div[3];
      MOD_OOK212: begin
        sc          = dout_q & div[5];
        ssp_clk_nxt = ~div[5];
        frame_nib   = div[8:5];
      end
      MOD_OOK424: sc = dout_q & div[4];
      MOD_SSP8:   begin
        sc          = dout_q & div[4];
        ssp_clk_nxt = ~div[7];
      end
      MOD_OOK848: sc = dout_q & div[3];
      default:    sc = 1'b0;
    endcase
  end

  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      ssp_clk   <= 1'b0;
      ssp_clk_q <= 1'b0;
      ssp_frame <= 1'b0;
      ssp_din   <= 1'b0;
      dout_q    <= 1'b0;
      pwr_oe4   <= 1'b0;
    end else begin
      ssp_clk   <= ssp_clk_nxt;
      ssp_clk_q <= ssp_clk;
      dout_q    <= ssp_dout;
      pwr_oe4   <= sc & field_on;
      if (frame_nib == 4'd1) begin
        ssp_frame <= 1'b1;
      end else if (frame_nib == 4'd5) begin
        ssp_frame <= 1'b0;
      end
      // Rising edge of the registered bit clock, detected in the carrier domain.
      if (ssp_clk && !ssp_clk_q) begin
        ssp_din <= hyst;
      end
    end
  end

  // Field detect: the terminal count always triggers the transition, so fcnt never wraps.
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      state <= NO_FIELD;
      fcnt  <= '0;
    end else begin
      case (state)
        NO_FIELD: begin
          if (adc_high) begin
            if (fcnt == ON_TC) begin
              state <= FIELD_ON;
              fcnt  <= '0;
            end else begin
              fcnt <= fcnt + FCNT_W'(1);
            end
          end else begin
            fcnt <= '0;
          end
        end
        default: begin
          if (adc_low) begin
            if (fcnt == OFF_TC) begin
              state <= NO_FIELD;
              fcnt  <= '0;
            end else begin
              fcnt <= fcnt + FCNT_W'(1);
            end
          end else begin
            fcnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hi_simulate_param.sv
`timescale 1ns/1ps
// Directed bench for hi_simulate_param: reset, SSP timing, field detect, modulation modes, comparator, async reset.
module tb_hi_simulate_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] adc_d;
  logic [3:0] mod_type;
  logic       ssp_dout;
  logic       adc_clk, ssp_clk, ssp_frame, ssp_din, pwr_oe4;
  logic       pwr_lo, pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3, field_on, dbg;

  hi_simulate_param dut (
    .ck_1356meg (clk),
    .rst_n      (rst_n),
    .adc_d      (adc_d),
    .mod_type   (mod_type),
    .ssp_dout   (ssp_dout),
    .adc_clk    (adc_clk),
    .ssp_clk    (ssp_clk),
    .ssp_frame  (ssp_frame),
    .ssp_din    (ssp_din),
    .pwr_oe4    (pwr_oe4),
    .pwr_lo     (pwr_lo),
    .pwr_hi     (pwr_hi),
    .pwr_oe1    (pwr_oe1),
    .pwr_oe2    (pwr_oe2),
    .pwr_oe3    (pwr_oe3),
    .field_on   (field_on),
    .dbg        (dbg)
  );

  // clock / reset-relative cycle count (posedges since reset release)
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic bitof(input int v, input int b);
    return ((v >> b) & 1) != 0;
  endfunction

  typedef struct {
    logic [3:0] mode;
    logic       d;
    int         bitpos;
    logic       inv;
    logic       en;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int   bad_clk, bad_frm, bad_dbg, seen_pwr, rises, ones, bad, nib;
    logic prev, e, found;

    adc_d    = 8'd0;
    mod_type = 4'd3;
    ssp_dout = 1'b1;

    // reset state
    cycles(3);
    check("rst_ssp_clk",   ssp_clk,   0);
    check("rst_ssp_frame", ssp_frame, 0);
    check("rst_ssp_din",   ssp_din,   0);
    check("rst_pwr_oe4",   pwr_oe4,   0);
    check("rst_field_on",  field_on,  0);
    check("rst_dbg",       dbg,       0);
    check("rst_ties", {pwr_lo, pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3}, 0);
    check("adc_clk_low", adc_clk, 0);
    @(posedge clk);
    #1;
    check("adc_clk_high", adc_clk, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // no field, mode 3: ssp_clk /32, frame window, no modulation
    bad_clk = 0; bad_frm = 0; bad_dbg = 0; seen_pwr = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      e = !bitof(cyc - 1, 4);
      if (ssp_clk !== e) bad_clk++;
      nib = ((cyc - 1) >> 4) & 15;
      e = (nib >= 1 && nib <= 4);
      if (ssp_frame !== e) bad_frm++;
      if (dbg !== ssp_frame) bad_dbg++;
      if (pwr_oe4) seen_pwr++;
      if (ssp_clk && !prev) rises++;
      prev = ssp_clk;
    end
    check("ssp_clk_div32", bad_clk, 0);
    check("ssp_clk_rises", rises, 313);
    check("ssp_frame_win", bad_frm, 0);
    check("dbg_is_frame", bad_dbg, 0);
    check("nofield_pwr", seen_pwr, 0);
    check("nofield_state", field_on, 0);
    check("din_low", ssp_din, 0);

    // field rises on the 64th consecutive high sample
    adc_d = 8'd240;
    cycles(63);
    check("field_63", field_on, 0);
    cycles(1);
    check("field_64", field_on, 1);
    adc_d = 8'd128;

    // modulation table with field present
    tbl[0] = '{4'd2,  1'b1, 5, 1'b0, 1'b1};
    tbl[1] = '{4'd3,  1'b1, 4, 1'b0, 1'b1};
    tbl[2] = '{4'd4,  1'b1, 4, 1'b0, 1'b1};
    tbl[3] = '{4'd5,  1'b1, 3, 1'b0, 1'b1};
    tbl[4] = '{4'd1,  1'b1, 3, 1'b1, 1'b1};
    tbl[5] = '{4'd1,  1'b0, 3, 1'b0, 1'b1};
    tbl[6] = '{4'd0,  1'b1, 0, 1'b0, 1'b0};
    tbl[7] = '{4'd6,  1'b1, 0, 1'b0, 1'b0};
    tbl[8] = '{4'd15, 1'b1, 0, 1'b0, 1'b0};
    tbl[9] = '{4'd5,  1'b0, 0, 1'b0, 1'b0};
    for (int t = 0; t < 10; t++) begin
      mod_type = tbl[t].mode;
      ssp_dout = tbl[t].d;
      cycles(4);
      bad = 0; ones = 0;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        e = tbl[t].en ? (bitof(cyc - 1, tbl[t].bitpos) ^ tbl[t].inv) : 1'b0;
        if (pwr_oe4 !== e) bad++;
        if (pwr_oe4) ones++;
      end
      check($sformatf("mode%0d_d%0d_wave", tbl[t].mode, tbl[t].d), bad, 0);
      check($sformatf("mode%0d_d%0d_duty", tbl[t].mode, tbl[t].d), ones, tbl[t].en ? 32 : 0);
    end

    // ssp_dout -> pwr_oe4 latency: phase inverts on the second edge
    mod_type = 4'd1;
    ssp_dout = 1'b0;
    cycles(8);
    e = bitof(cyc - 1, 3);
    check("bpsk_d0", pwr_oe4, e);
    ssp_dout = 1'b1;
    cycles(1);
    e = bitof(cyc - 1, 3);
    check("bpsk_lat1", pwr_oe4, e);
    cycles(1);
    e = !bitof(cyc - 1, 3);
    check("bpsk_lat2", pwr_oe4, e);

    // comparator returned on ssp_din, sampled at ssp_clk rising edges
    mod_type = 4'd3;
    adc_d = 8'd240;
    cycles(80);
    check("din_240", ssp_din, 1);
    adc_d = 8'd128;
    cycles(64);
    check("din_128a", ssp_din, 1);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      prev = ssp_clk;
      @(negedge clk);
      if (ssp_clk && !prev) found = 1'b1;
    end
    check("ssp_rise_found", found, 1);
    cycles(4);
    adc_d = 8'd20;
    cycles(20);
    check("din_20_held", ssp_din, 1);
    cycles(16);
    check("din_20", ssp_din, 0);
    adc_d = 8'd128;
    cycles(64);
    check("din_128b", ssp_din, 0);
    check("field_kept", field_on, 1);

    // field lost after 256 low samples; modulation forced off
    ssp_dout = 1'b1;
    adc_d = 8'd0;
    seen_pwr = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      if (pwr_oe4) seen_pwr++;
    end
    check("field_255", field_on, 1);
    check("pwr_before_loss", seen_pwr > 0, 1);
    cycles(1);
    check("field_256", field_on, 0);
    seen_pwr = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (pwr_oe4) seen_pwr++;
    end
    check("pwr_after_loss", seen_pwr, 0);

    // hysteresis timeout (only with the optional feature)
    adc_d = 8'd240;
    cycles(1);
    adc_d = 8'd20;
    cycles(4095);
    check("hyst_4095", dut.hyst, 0);
    cycles(1);
`ifdef HI_SIM_HYST_TIMEOUT_EN
    check("hyst_4096", dut.hyst, 1);
`else
    check("hyst_4096", dut.hyst, 0);
`endif
    cycles(1);
    check("hyst_4097", dut.hyst, 0);

    // an interrupted high run restarts the field count
    adc_d = 8'd240;
    cycles(40);
    adc_d = 8'd128;
    cycles(1);
    adc_d = 8'd240;
    cycles(63);
    check("field_restart_63", field_on, 0);
    cycles(1);
    check("field_restart_64", field_on, 1);

    // async reset during mode 5 modulation
    adc_d = 8'd128;
    mod_type = 4'd5;
    ssp_dout = 1'b1;
    cycles(4);
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge clk);
      if (pwr_oe4) found = 1'b1;
    end
    check("m5_active", found, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pwr_oe4",   pwr_oe4,   0);
    check("arst_ssp_clk",   ssp_clk,   0);
    check("arst_ssp_frame", ssp_frame, 0);
    check("arst_ssp_din",   ssp_din,   0);
    check("arst_field_on",  field_on,  0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
    check("resume_ssp_clk", ssp_clk, 1);
    check("resume_field",   field_on, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
